// File: rtl/pfc_rx_ctrl.sv
// Receive-side MAC-control flow-control engine: parses 802.3x PAUSE and
// 802.1Qbb PFC frames and keeps one pause-quanta timer per priority class.
module pfc_rx_ctrl #(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned QUANTA_CYC  = 64,
  parameter int unsigned MIN_LEN     = 64,
  parameter int unsigned MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [7:0]             rx_data,
  input  logic                   rx_dv,
  input  logic                   frame_end,
  input  logic                   frame_good,
  input  logic [15:0]            frame_len,
  input  logic [47:0]            station_addr,
  input  logic                   pfc_enable,
  output logic [NUM_CLASSES-1:0] pause_o,
  output logic                   pause_rcvd,
  output logic                   pfc_rcvd,
  output logic                   ctrl_frame,
  output logic                   bad_opcode
);

  localparam int unsigned PW       = (QUANTA_CYC > 1) ? $clog2(QUANTA_CYC) : 1;
  localparam logic [47:0] MC_DA    = 48'h0180_C200_0001;
  localparam logic [15:0] OP_PAUSE = 16'h0001;
  localparam logic [15:0] OP_PFC   = 16'h0101;

  logic                         rxDvPrev;
  logic [5:0]                   byteIdx;
  logic                         daMcast;
  logic                         daUcast;
  logic                         typeHi;
  logic                         typeOk;
  logic [15:0]                  opcode;
  logic [15:0]                  pauseQ;
  logic [7:0]                   pfcVec;
  logic [NUM_CLASSES-1:0][15:0] pfcQ;
  logic [NUM_CLASSES-1:0][15:0] timer;
  logic [NUM_CLASSES-1:0][15:0] timerNext;
  logic [NUM_CLASSES-1:0]       activeNext;
  logic [NUM_CLASSES-1:0]       load;
  logic [PW-1:0]                presc;
  logic [PW-1:0]                prescNext;

  logic       firstByte;
  logic [5:0] curIdx;
  logic [7:0] mcastByte;
  logic [7:0] ucastByte;
  logic       daMcastCur;
  logic       daUcastCur;
  logic       lenOk;
  logic       ctrlOk;
  logic       doPause;
  logic       doPfc;
  logic       anyActive;
  logic       tick;

  // A rising rx_dv starts a new frame and restarts the byte index at 0.
  assign firstByte  = rx_dv & ~rxDvPrev;
  assign curIdx     = firstByte ? 6'd0 : byteIdx;
  assign daMcastCur = firstByte | daMcast;
  assign daUcastCur = firstByte | daUcast;

  always_comb begin
    mcastByte = 8'h00;
    ucastByte = 8'h00;
    case (curIdx)
      6'd0: begin mcastByte = MC_DA[47:40]; ucastByte = station_addr[47:40]; end
      6'd1: begin mcastByte = MC_DA[39:32]; ucastByte = station_addr[39:32]; end
      6'd2: begin mcastByte = MC_DA[31:24]; ucastByte = station_addr[31:24]; end
      6'd3: begin mcastByte = MC_DA[23:16]; ucastByte = station_addr[23:16]; end
      6'd4: begin mcastByte = MC_DA[15:8];  ucastByte = station_addr[15:8];  end
      6'd5: begin mcastByte = MC_DA[7:0];   ucastByte = station_addr[7:0];   end
      default: ;
    endcase
  end

  assign lenOk   = (frame_len >= 16'(MIN_LEN)) && (frame_len <= 16'(MAX_LEN));
  assign ctrlOk  = frame_end & frame_good & typeOk & lenOk;
  assign doPause = ctrlOk & (daMcast | daUcast) & (opcode == OP_PAUSE);
  assign doPfc   = ctrlOk & (daMcast | daUcast) & (opcode == OP_PFC) & pfc_enable;

  // Timer next-state: a load beats a coincident tick for that class only.
  always_comb begin
    anyActive  = 1'b0;
    timerNext  = timer;
    load       = '0;
    activeNext = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (timer[i] != 16'd0) anyActive = 1'b1;
    end
    tick = anyActive && (presc == PW'(QUANTA_CYC - 1));
    for (int i = 0; i < NUM_CLASSES; i++) begin
      load[i] = doPause | (doPfc & pfcVec[i]);
      if (load[i])
        timerNext[i] = doPause ? pauseQ : pfcQ[i];
      else if (tick && (timer[i] != 16'd0))
        timerNext[i] = timer[i] - 16'd1;
      activeNext[i] = (timerNext[i] != 16'd0);
    end
    if ((|load) || !anyActive || tick)
      prescNext = '0;
    else
      prescNext = presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxDvPrev   <= 1'b0;
      byteIdx    <= 6'd0;
      daMcast    <= 1'b0;
      daUcast    <= 1'b0;
      typeHi     <= 1'b0;
      typeOk     <= 1'b0;
      opcode     <= 16'd0;
      pauseQ     <= 16'd0;
      pfcVec     <= 8'd0;
      pfcQ       <= '0;
      timer      <= '0;
      presc      <= '0;
      pause_o    <= '0;
      pause_rcvd <= 1'b0;
      pfc_rcvd   <= 1'b0;
      ctrl_frame <= 1'b0;
      bad_opcode <= 1'b0;
    end else if (en) begin
      rxDvPrev <= rx_dv;
      if (rx_dv) begin
        byteIdx <= (curIdx == 6'd63) ? 6'd63 : curIdx + 6'd1;
        // Restarting a frame discards everything captured from the previous one.
        if (firstByte) begin
          typeHi <= 1'b0;
          typeOk <= 1'b0;
          opcode <= 16'd0;
          pauseQ <= 16'd0;
          pfcVec <= 8'd0;
          pfcQ   <= '0;
        end
        if (curIdx < 6'd6) begin
          daMcast <= daMcastCur & (rx_data == mcastByte);
          daUcast <= daUcastCur & (rx_data == ucastByte);
        end
        case (curIdx)
          6'd12: typeHi <= (rx_data == 8'h88);
          6'd13: typeOk <= typeHi & (rx_data == 8'h08);
          6'd14: opcode[15:8] <= rx_data;
          6'd15: opcode[7:0]  <= rx_data;
          6'd16: pauseQ[15:8] <= rx_data;
          6'd17: begin
            pauseQ[7:0] <= rx_data;
            pfcVec      <= rx_data;
          end
          default: ;
        endcase
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (curIdx == 6'(18 + 2 * i)) pfcQ[i][15:8] <= rx_data;
          if (curIdx == 6'(19 + 2 * i)) pfcQ[i][7:0]  <= rx_data;
        end
      end
      timer      <= timerNext;
      presc      <= prescNext;
      pause_o    <= activeNext;
      pause_rcvd <= doPause;
      pfc_rcvd   <= doPfc;
      ctrl_frame <= ctrlOk;
      bad_opcode <= ctrlOk & (opcode != OP_PAUSE) & (opcode != OP_PFC);
    end
  end

endmodule

// File: tb/tb_pfc_rx_ctrl.sv
// Directed self-checking bench for pfc_rx_ctrl: PAUSE, PFC, rejects, XON,
// load/tick coincidence, bad opcode with en gating, abort and reset.
module tb_pfc_rx_ctrl;

  localparam logic [47:0] MC  = 48'h0180_C200_0001;
  localparam logic [47:0] STA = 48'h0200_00AA_BBCC;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        frame_end;
  logic        frame_good;
  logic [15:0] frame_len;
  logic [47:0] station_addr;
  logic        pfc_enable;
  logic [7:0]  pause_o;
  logic        pause_rcvd;
  logic        pfc_rcvd;
  logic        ctrl_frame;
  logic        bad_opcode;

  int unsigned cyc = 0;
  int          passCnt = 0;
  int          totalCnt = 0;
  bit          toggleEn = 1'b0;
  logic [7:0]  frm [64];

  pfc_rx_ctrl #(.NUM_CLASSES(8), .QUANTA_CYC(64), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst(rst), .en(en), .rx_data(rx_data), .rx_dv(rx_dv),
    .frame_end(frame_end), .frame_good(frame_good), .frame_len(frame_len),
    .station_addr(station_addr), .pfc_enable(pfc_enable), .pause_o(pause_o),
    .pause_rcvd(pause_rcvd), .pfc_rcvd(pfc_rcvd), .ctrl_frame(ctrl_frame),
    .bad_opcode(bad_opcode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // One enabled cycle; in toggle mode an en=0 cycle precedes it.
  task automatic step();
    if (toggleEn) begin
      en = 1'b0;
      @(posedge clk); #1;
      en = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic waitUntil(input int unsigned target);
    while (cyc < target) step();
  endtask

  task automatic buildHdr(input logic [47:0] da, input logic [15:0] op);
    for (int i = 0; i < 64; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) frm[i] = da[8*(5-i) +: 8];
    frm[6] = 8'h02; frm[11] = 8'h01;
    frm[12] = 8'h88; frm[13] = 8'h08;
    frm[14] = op[15:8]; frm[15] = op[7:0];
  endtask

  task automatic buildPause(input logic [47:0] da, input logic [15:0] q);
    buildHdr(da, 16'h0001);
    frm[16] = q[15:8]; frm[17] = q[7:0];
  endtask

  task automatic buildPfc(input logic [47:0] da, input logic [7:0] e, input logic [127:0] qs);
    buildHdr(da, 16'h0101);
    frm[16] = 8'h00; frm[17] = e;
    for (int i = 0; i < 8; i++) begin
      frm[18+2*i] = qs[16*i+8 +: 8];
      frm[19+2*i] = qs[16*i +: 8];
    end
  endtask

  // endAt != 0 places the frame_end edge at that absolute cycle count.
  task automatic sendFrame(input int nBytes, input logic good, input logic [15:0] len,
                           input int unsigned endAt);
    for (int i = 0; i < nBytes; i++) begin
      rx_dv = 1'b1; rx_data = frm[i]; step();
    end
    rx_dv = 1'b0; rx_data = 8'h00; step();
    while (endAt != 0 && cyc < endAt - 1) step();
    frame_end = 1'b1; frame_good = good; frame_len = len; step();
    frame_end = 1'b0; frame_good = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rx_dv = 1'b0; rx_data = 8'h00; frame_end = 1'b0;
    frame_good = 1'b0; frame_len = 16'd0; station_addr = STA; pfc_enable = 1'b1;
    @(posedge clk); #1; step(); step();
    totalCnt++; if (pause_o !== 8'h00) $display("FAIL reset_pause: got %h want 00", pause_o); else passCnt++;
    totalCnt++; if ({pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode}); else passCnt++;
    rst = 1'b0; step();
  endtask

  task automatic test_pause();
    int unsigned t;
    buildPause(MC, 16'h0003);
    sendFrame(64, 1'b1, 16'd64, 0);
    t = cyc;
    totalCnt++; if (pause_o !== 8'hFF) $display("FAIL pause_on: got %h want ff", pause_o); else passCnt++;
    totalCnt++; if ({pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode} !== 4'b1010)
      $display("FAIL pause_pulses: got %b want 1010", {pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode}); else passCnt++;
    step();
    totalCnt++; if (pause_rcvd !== 1'b0) $display("FAIL pause_rcvd_once: got %b want 0", pause_rcvd); else passCnt++;
    waitUntil(t + 191);
    totalCnt++; if (pause_o !== 8'hFF) $display("FAIL pause_hold191: got %h want ff", pause_o); else passCnt++;
    step();
    totalCnt++; if (pause_o !== 8'h00) $display("FAIL pause_off192: got %h want 00", pause_o); else passCnt++;
  endtask

  task automatic test_pfc();
    int unsigned t;
    buildPfc(MC, 8'h05, {96'h0, 16'd1, 16'd0, 16'd2});
    sendFrame(64, 1'b1, 16'd64, 0);
    t = cyc;
    totalCnt++; if (pause_o !== 8'h05) $display("FAIL pfc_on: got %h want 05", pause_o); else passCnt++;
    totalCnt++; if ({pause_rcvd, pfc_rcvd} !== 2'b01) $display("FAIL pfc_pulse: got %b want 01", {pause_rcvd, pfc_rcvd}); else passCnt++;
    waitUntil(t + 63);
    totalCnt++; if (pause_o !== 8'h05) $display("FAIL pfc_t63: got %h want 05", pause_o); else passCnt++;
    step();
    totalCnt++; if (pause_o !== 8'h01) $display("FAIL pfc_t64: got %h want 01", pause_o); else passCnt++;
    waitUntil(t + 127);
    totalCnt++; if (pause_o !== 8'h01) $display("FAIL pfc_t127: got %h want 01", pause_o); else passCnt++;
    step();
    totalCnt++; if (pause_o !== 8'h00) $display("FAIL pfc_t128: got %h want 00", pause_o); else passCnt++;
  endtask

  task automatic test_reject();
    buildPfc(MC, 8'h05, {96'h0, 16'd1, 16'd0, 16'd2});
    sendFrame(64, 1'b0, 16'd64, 0);
    totalCnt++; if ({pause_o, pfc_rcvd, ctrl_frame} !== 10'h000)
      $display("FAIL rej_bad_crc: got %h want 000", {pause_o, pfc_rcvd, ctrl_frame}); else passCnt++;
    sendFrame(64, 1'b1, 16'd1519, 0);
    totalCnt++; if ({pause_o, pfc_rcvd, ctrl_frame} !== 10'h000)
      $display("FAIL rej_len1519: got %h want 000", {pause_o, pfc_rcvd, ctrl_frame}); else passCnt++;
    sendFrame(64, 1'b1, 16'd63, 0);
    totalCnt++; if ({pause_o, pfc_rcvd, ctrl_frame} !== 10'h000)
      $display("FAIL rej_len63: got %h want 000", {pause_o, pfc_rcvd, ctrl_frame}); else passCnt++;
    buildPfc(STA, 8'h05, {96'h0, 16'd1, 16'd0, 16'd2});
    frm[4] = frm[4] ^ 8'h01;
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if ({pause_o, pfc_rcvd, ctrl_frame} !== 10'h001)
      $display("FAIL rej_da_mismatch: got %h want 001", {pause_o, pfc_rcvd, ctrl_frame}); else passCnt++;
    pfc_enable = 1'b0;
    buildPfc(MC, 8'h05, {96'h0, 16'd1, 16'd0, 16'd2});
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if ({pause_o, pfc_rcvd, ctrl_frame, bad_opcode} !== 11'h002)
      $display("FAIL rej_pfc_disabled: got %h want 002", {pause_o, pfc_rcvd, ctrl_frame, bad_opcode}); else passCnt++;
    pfc_enable = 1'b1;
    buildPause(STA, 16'h0000);
    sendFrame(64, 1'b1, 16'd1518, 0);
    totalCnt++; if ({pause_o, pause_rcvd} !== 9'h001)
      $display("FAIL ucast_len1518: got %h want 001", {pause_o, pause_rcvd}); else passCnt++;
  endtask

  task automatic test_xon();
    buildPause(MC, 16'h0100);
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if (pause_o !== 8'hFF) $display("FAIL xon_pre: got %h want ff", pause_o); else passCnt++;
    for (int i = 0; i < 10; i++) step();
    buildPause(MC, 16'h0000);
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if ({pause_o, pause_rcvd} !== 9'h001)
      $display("FAIL xon_clear: got %h want 001", {pause_o, pause_rcvd}); else passCnt++;
  endtask

  task automatic test_coincident();
    int unsigned t;
    buildPfc(MC, 8'h08, {64'h0, 16'd6, 48'h0});
    sendFrame(64, 1'b1, 16'd64, 0);
    t = cyc;
    totalCnt++; if (pause_o !== 8'h08) $display("FAIL coin_first: got %h want 08", pause_o); else passCnt++;
    buildPfc(MC, 8'h02, {96'h0, 16'd7, 16'd0});
    sendFrame(64, 1'b1, 16'd64, t + 128);
    totalCnt++; if ({pause_o, pfc_rcvd} !== 9'h015) $display("FAIL coin_load: got %h want 015", {pause_o, pfc_rcvd}); else passCnt++;
    waitUntil(t + 383);
    totalCnt++; if (pause_o !== 8'h0A) $display("FAIL coin_c3_hold: got %h want 0a", pause_o); else passCnt++;
    step();
    totalCnt++; if (pause_o !== 8'h02) $display("FAIL coin_c3_off: got %h want 02", pause_o); else passCnt++;
    waitUntil(t + 575);
    totalCnt++; if (pause_o !== 8'h02) $display("FAIL coin_c1_hold: got %h want 02", pause_o); else passCnt++;
    step();
    totalCnt++; if (pause_o !== 8'h00) $display("FAIL coin_c1_off: got %h want 00", pause_o); else passCnt++;
  endtask

  task automatic test_bad_opcode();
    buildHdr(MC, 16'h0002);
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if ({pause_o, pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode} !== 12'h003)
      $display("FAIL badop: got %h want 003", {pause_o, pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode}); else passCnt++;
    step();
    totalCnt++; if ({ctrl_frame, bad_opcode} !== 2'b00) $display("FAIL badop_once: got %b want 00", {ctrl_frame, bad_opcode}); else passCnt++;
    toggleEn = 1'b1;
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if ({pause_o, pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode} !== 12'h003)
      $display("FAIL badop_en: got %h want 003", {pause_o, pause_rcvd, pfc_rcvd, ctrl_frame, bad_opcode}); else passCnt++;
    toggleEn = 1'b0;
    en = 1'b0; @(posedge clk); #1;
    totalCnt++; if ({ctrl_frame, bad_opcode} !== 2'b11) $display("FAIL badop_held: got %b want 11", {ctrl_frame, bad_opcode}); else passCnt++;
    en = 1'b1; step();
    totalCnt++; if ({ctrl_frame, bad_opcode} !== 2'b00) $display("FAIL badop_en_once: got %b want 00", {ctrl_frame, bad_opcode}); else passCnt++;
  endtask

  task automatic test_abort();
    buildPause(MC, 16'h0005);
    for (int i = 0; i < 20; i++) begin
      rx_dv = 1'b1; rx_data = frm[i]; step();
    end
    rx_dv = 1'b0; step();
    sendFrame(10, 1'b1, 16'd64, 0);
    totalCnt++; if ({pause_o, pause_rcvd, ctrl_frame} !== 10'h000)
      $display("FAIL abort: got %h want 000", {pause_o, pause_rcvd, ctrl_frame}); else passCnt++;
  endtask

  task automatic test_rst_active();
    buildPause(MC, 16'h0005);
    sendFrame(64, 1'b1, 16'd64, 0);
    totalCnt++; if (pause_o !== 8'hFF) $display("FAIL rst_pre: got %h want ff", pause_o); else passCnt++;
    step(); step();
    rst = 1'b1; step();
    totalCnt++; if (pause_o !== 8'h00) $display("FAIL rst_drop: got %h want 00", pause_o); else passCnt++;
    rst = 1'b0; step(); step();
    totalCnt++; if (pause_o !== 8'h00) $display("FAIL rst_stays: got %h want 00", pause_o); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_pause();
    test_pfc();
    test_reject();
    test_xon();
    test_coincident();
    test_bad_opcode();
    test_abort();
    test_rst_active();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
